// File: rtl/semaforo_button_cond.sv
//------------------------------------------------------------------------------
// semaforo_button_cond: synchronizes and debounces the pedestrian push-button,
// then emits a press strobe, a latched request (cleared by ack) and a counter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module semaforo_button_cond #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       button_n,
   input  logic       ack,
   output logic       press_pulse,
   output logic       request,
   output logic       pressed,
   output logic [7:0] press_count
);

   typedef enum logic [1:0] {
      RELEASED      = 2'd0,
      PRESS_CHECK   = 2'd1,
      HELD          = 2'd2,
      RELEASE_CHECK = 2'd3
   } state_t;

   localparam logic [23:0] LAST_CNT = 24'(DEBOUNCE_CYCLES - 1);

   state_t      state_q, state_d;
   logic        sync1_q, sync2_q;
   logic [23:0] cnt_q, cnt_d;
   logic        pulse_q, pulse_d;
   logic        request_q, request_d;
   logic [7:0]  count_q, count_d;
   logic        cnt_last;

   // Synchronizer idles high so reset looks like a released button.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= button_n;
         sync2_q <= sync1_q;
      end
   end

   assign cnt_last = (cnt_q == LAST_CNT);

   always_comb begin
      state_d = state_q;
      case (state_q)
         RELEASED:      if (!sync2_q) state_d = PRESS_CHECK;
         PRESS_CHECK:   if (sync2_q) state_d = RELEASED;
                        else if (cnt_last) state_d = HELD;
         HELD:          if (sync2_q) state_d = RELEASE_CHECK;
         RELEASE_CHECK: if (!sync2_q) state_d = HELD;
                        else if (cnt_last) state_d = RELEASED;
         default:       state_d = RELEASED;
      endcase
   end

   always_comb begin
      cnt_d = '0;
      if (state_d == state_q &&
          (state_q == PRESS_CHECK || state_q == RELEASE_CHECK)) begin
         cnt_d = cnt_q + 24'd1;
      end
   end

   // Only a qualified press (not a release-bounce return) raises the strobe.
   assign pulse_d   = (state_q == PRESS_CHECK) && (state_d == HELD);
   assign request_d = pulse_q ? 1'b1 : (ack ? 1'b0 : request_q);
   assign count_d   = pulse_q ? count_q + 8'd1 : count_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= RELEASED;
         cnt_q     <= '0;
         pulse_q   <= 1'b0;
         request_q <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pulse_q   <= pulse_d;
         request_q <= request_d;
         count_q   <= count_d;
      end
   end

   assign press_pulse = pulse_q;
   assign request     = request_q;
   assign pressed     = (state_q == HELD) || (state_q == RELEASE_CHECK);
   assign press_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_semaforo_button_cond.sv
//------------------------------------------------------------------------------
// tb_semaforo_button_cond: directed self-checking bench, DEBOUNCE_CYCLES = 4.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_semaforo_button_cond;

   logic       clk;
   logic       rst;
   logic       button_n;
   logic       ack;
   logic       press_pulse;
   logic       request;
   logic       pressed;
   logic [7:0] press_count;

   int checks = 0;
   int errors = 0;
   int pulse_total = 0;
   int base;
   int lat;
   logic found;

   semaforo_button_cond #(.DEBOUNCE_CYCLES(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .button_n    (button_n),
      .ack         (ack),
      .press_pulse (press_pulse),
      .request     (request),
      .pressed     (pressed),
      .press_count (press_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (press_pulse === 1'b1) pulse_total++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_pulse(input string tag);
      found = 1'b0;
      lat   = 0;
      for (int i = 1; i <= 12 && !found; i++) begin
         tick();
         if (press_pulse === 1'b1) begin
            found = 1'b1;
            lat   = i;
         end
      end
      check({tag, "_found"}, 32'(found), 32'd1);
      check({tag, "_lat_le7"}, 32'(lat <= 7), 32'd1);
   endtask

   task automatic press_release();
      button_n = 1'b0;
      repeat (10) tick();
      button_n = 1'b1;
      repeat (10) tick();
   endtask

   initial begin
      rst = 1'b0; button_n = 1'b1; ack = 1'b0;
      repeat (3) tick();
      check("rst_pulse", 32'(press_pulse), 0);
      check("rst_request", 32'(request), 0);
      check("rst_pressed", 32'(pressed), 0);
      check("rst_count", 32'(press_count), 0);
      rst = 1'b1;
      tick();
      check("post_rst_pressed", 32'(pressed), 0);
      check("post_rst_pulse", 32'(press_pulse), 0);
      repeat (3) tick();

      // Clean press held 20 cycles
      base = pulse_total;
      button_n = 1'b0;
      wait_pulse("clean");
      tick();
      check("clean_single", 32'(press_pulse), 0);
      check("clean_request", 32'(request), 1);
      check("clean_count", 32'(press_count), 1);
      check("clean_pressed", 32'(pressed), 1);
      repeat (12) tick();
      check("clean_no_repeat", 32'(pulse_total - base), 1);

      // Handshake clear
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("ack_clear", 32'(request), 0);

      // Release bounce while held
      base = pulse_total;
      button_n = 1'b1;
      repeat (2) tick();
      button_n = 1'b0;
      repeat (8) tick();
      check("relbounce_pressed", 32'(pressed), 1);
      check("relbounce_no_pulse", 32'(pulse_total - base), 0);
      button_n = 1'b1;
      found = 1'b0; lat = 0;
      for (int i = 1; i <= 12 && !found; i++) begin
         tick();
         if (pressed === 1'b0) begin found = 1'b1; lat = i; end
      end
      check("release_found", 32'(found), 1);
      check("release_lat_le7", 32'(lat <= 7), 1);
      repeat (5) tick();

      // Press bounce: low 2, high 1, low 2, high
      base = pulse_total;
      button_n = 1'b0; repeat (2) tick();
      button_n = 1'b1; tick();
      button_n = 1'b0; repeat (2) tick();
      button_n = 1'b1; repeat (10) tick();
      check("bounce_no_pulse", 32'(pulse_total - base), 0);
      check("bounce_request", 32'(request), 0);
      check("bounce_count", 32'(press_count), 1);
      check("bounce_pressed", 32'(pressed), 0);

      // ack coincident with press_pulse: set wins
      button_n = 1'b0;
      wait_pulse("coinc");
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("coinc_request", 32'(request), 1);
      check("coinc_count", 32'(press_count), 2);
      button_n = 1'b1;
      repeat (12) tick();
      check("ack_idle_noeffect", 32'(request), 1);

      // Wrap: total of 256 presses
      for (int k = 0; k < 253; k++) press_release();
      check("wrap_255", 32'(press_count), 255);
      press_release();
      check("wrap_zero", 32'(press_count), 0);
      check("wrap_pulses", 32'(pulse_total), 256);
      press_release();
      check("post_wrap_count", 32'(press_count), 1);

      // Reset in PRESS_CHECK with button held
      base = pulse_total;
      button_n = 1'b0;
      repeat (4) tick();
      rst = 1'b0;
      #1;
      check("midrst_request", 32'(request), 0);
      check("midrst_count", 32'(press_count), 0);
      check("midrst_pressed", 32'(pressed), 0);
      check("midrst_pulse", 32'(press_pulse), 0);
      repeat (3) tick();
      rst = 1'b1;
      wait_pulse("requal");
      tick();
      check("requal_count", 32'(press_count), 1);
      check("requal_pressed", 32'(pressed), 1);
      repeat (10) tick();
      check("requal_one_pulse", 32'(pulse_total - base), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL timeout: simulation did not finish, observed running expected done");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
